phys_reg_free_list: RTL and testbench
=====================================

# phys_reg_free_list

Allocator for physical registers in the renaming stage, deciding which `phys_reg_file` entries each dispatched destination receives.
- Hands out up to SS free physical register indices per cycle to dispatch.
- Reclaims the previous mapping of each committed destination from the ROB.
- On flush, rolls all speculatively allocated registers back into the free pool.
- Sits between dispatch/rename, the ROB commit port and the register file.

## Interface
- SS, 2, superscalar width (allocation and commit ways)
- TABLE_ENTRIES, 64, physical registers in `phys_reg_file`
- ARCH_REGS, 32, architectural registers; physical 0..ARCH_REGS-1 are mapped at reset
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- alloc_req[SS]  in  1  way i needs a destination register
- alloc_gnt  out  1  all requested ways granted this cycle
- alloc_preg[SS]  out  $clog2(TABLE_ENTRIES)  index granted to way i; valid when alloc_gnt and alloc_req[i]
- commit_en[SS]  in  1  way i retires an instruction that allocated a register
- commit_old_preg[SS]  in  $clog2(TABLE_ENTRIES)  stale mapping freed by that commit
- flush  in  1  mispredict/exception; discard speculative allocations
- free_count  out  $clog2(DEPTH)+1  free entries available
- err  out  1  sticky protocol error

## Operation
- DEPTH = TABLE_ENTRIES-ARCH_REGS.
- Circular buffer of DEPTH indices. Three pointers, each with an extra wrap bit:
  - head: speculative allocation
  - commit_head: committed allocation
  - tail: push
- free_count = tail-head, modulo 2·DEPTH.
- Allocation is all-or-nothing.
  - n_req = popcount(alloc_req).
  - alloc_gnt = !flush && n_req ≤ free_count. It is asserted even when n_req = 0.
  - Way i reads entry head + popcount(alloc_req[0..i-1]), so grants compact in way order.
  - On grant, head += n_req.
- Commit:
  - n_com = popcount(commit_en).
  - Way i writes commit_old_preg[i] at tail + popcount(commit_en[0..i-1]).
  - tail += n_com; commit_head += n_com.
- Flush: head ← commit_head + n_com, where n_com counts commits in the same cycle. No grant is issued that cycle.
- err sets if any of these occurs:
  - n_com would make free_count exceed DEPTH;
  - commit_head would pass head;
  - commit_old_preg is 0.

  err is cleared only by reset.
- Reset:
  - entry k = ARCH_REGS+k;
  - head = commit_head = 0;
  - tail = DEPTH, wrap bit set, index 0;
  - free_count = DEPTH; err = 0.

## Timing
- alloc_gnt and alloc_preg are combinational from registered state and alloc_req/flush. Zero-cycle grant.
- Pointer and storage updates occur at posedge clk.
- No bypass: an index pushed in cycle t is allocatable from cycle t+1.
- Simultaneous alloc and commit are allowed: free_count_next = free_count - n_req·gnt + n_com.
- Empty: free_count = 0. Any nonzero request is denied; an n_req = 0 cycle still grants.
- Wrap-around: indices wrap modulo DEPTH. Full vs empty is distinguished by the wrap bit only.
- Flush has priority over allocation. Commits are never dropped.
- Asynchronous reset mid-operation returns all state to reset values immediately. Outputs reflect reset state while rst = 0.

## Structure
- Shared `rv32i_types` package:
  - `PREG_IDX_W = $clog2(TABLE_ENTRIES)`;
  - `FREE_DEPTH`;
  - typedef `preg_idx_t`;
  - a `popcount_ss` function.
- Single module. Storage is a flop array, not SRAM, because of multi-port compacted read/write. No sub-module required.

## Test plan
- Reset, then alloc_req = 2'b11 → gnt = 1, alloc_preg = {32, 33}. Next cycle free_count = 30.
- alloc_req = 2'b10 from reset → way 1 receives 32 (compaction); head advances 1.
- Allocate all 32 entries, then request 2'b01 → gnt = 0, free_count = 0. Same-cycle commit of preg 5 → next cycle request 2'b01 gets 5.
- Allocate 4 entries (commit_head = 0), commit 1 with old preg 7, then flush → free_count = 32-4+1+3 = 32. Next grants restart at entry 1, index 33.
- Cycle commit/alloc pairs through more than 64 operations → indices wrap correctly, free_count stays constant, err = 0.
- Commit with free_count = 32 → err = 1. Assert rst = 0 asynchronously mid-cycle → err = 0 and free_count = 32 immediately.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared rename-stage types: physical register index, free-list geometry and
// a way-count popcount helper.
package rv32i_types;

  localparam int SS            = 2;
  localparam int TABLE_ENTRIES = 64;
  localparam int ARCH_REGS     = 32;

  localparam int PREG_IDX_W = $clog2(TABLE_ENTRIES);
  localparam int FREE_DEPTH = TABLE_ENTRIES - ARCH_REGS;
  // Free-list index width; FREE_DEPTH must be a power of two so the wrap bit
  // alone distinguishes full from empty.
  localparam int FL_IDX_W   = $clog2(FREE_DEPTH);
  localparam int FL_PTR_W   = FL_IDX_W + 1;
  localparam int SS_CNT_W   = $clog2(SS + 1);

  typedef logic [PREG_IDX_W-1:0] preg_idx_t;
  typedef logic [FL_PTR_W-1:0]   fl_ptr_t;

  function automatic logic [SS_CNT_W-1:0] popcount_ss(input logic [SS-1:0] v);
    logic [SS_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < SS; i++) cnt = cnt + SS_CNT_W'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular buffer of free indices with
// speculative (head), committed (commit_head) and push (tail) pointers.
module phys_reg_free_list
  import rv32i_types::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SS-1:0]       alloc_req,
  output logic                alloc_gnt,
  output preg_idx_t           alloc_preg [SS],
  input  logic [SS-1:0]       commit_en,
  input  preg_idx_t           commit_old_preg [SS],
  input  logic                flush,
  output logic [FL_IDX_W:0]   free_count,
  output logic                err
);

  fl_ptr_t             head, commit_head, tail;
  fl_ptr_t             head_next, commit_head_next, tail_next;
  fl_ptr_t             rd_ptr;
  fl_ptr_t             wr_ptr [SS];
  fl_ptr_t             spec_ahead;
  preg_idx_t           fl_mem [FREE_DEPTH];
  logic [SS_CNT_W-1:0] n_req, n_com;
  logic                zero_preg, overflow, passes_head;

  assign n_req      = popcount_ss(alloc_req);
  assign n_com      = popcount_ss(commit_en);
  assign free_count = tail - head;
  assign alloc_gnt  = !flush && (FL_PTR_W'(n_req) <= free_count);
  assign spec_ahead = head - commit_head;

  // Grants compact in way order: each requesting way consumes the next entry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_ptr = head;
    for (int i = 0; i < SS; i++) begin
      alloc_preg[i] = fl_mem[rd_ptr[FL_IDX_W-1:0]];
      if (alloc_req[i]) rd_ptr = rd_ptr + fl_ptr_t'(1);
    end
  end

  always_comb begin
    zero_preg = 1'b0;
    for (int i = 0; i < SS; i++) begin
      wr_ptr[i] = tail + fl_ptr_t'(popcount_ss(commit_en & SS'((1 << i) - 1)));
      if (commit_en[i] && commit_old_preg[i] == '0) zero_preg = 1'b1;
    end
  end

  assign overflow    = (FL_PTR_W + 1)'(free_count) + (FL_PTR_W + 1)'(n_com)
                       > (FL_PTR_W + 1)'(FREE_DEPTH);
  assign passes_head = spec_ahead < FL_PTR_W'(n_com);

  always_comb begin
    tail_next        = tail + FL_PTR_W'(n_com);
    commit_head_next = commit_head + FL_PTR_W'(n_com);
    head_next        = head;
    if (flush)          head_next = commit_head_next;
    else if (alloc_gnt) head_next = head + FL_PTR_W'(n_req);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head        <= '0;
      commit_head <= '0;
      tail        <= fl_ptr_t'(FREE_DEPTH);
      err         <= 1'b0;
      // NOTE: this storage is reset on purpose; its reset contents are the initial free pool.
      for (int k = 0; k < FREE_DEPTH; k++) fl_mem[k] <= preg_idx_t'(ARCH_REGS + k);
    end else begin
      head        <= head_next;
      commit_head <= commit_head_next;
      tail        <= tail_next;
      err         <= err | zero_preg | overflow | passes_head;
      for (int i = 0; i < SS; i++)
        if (commit_en[i]) fl_mem[wr_ptr[i][FL_IDX_W-1:0]] <= commit_old_preg[i];
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed self-checking bench for phys_reg_free_list.
module tb_phys_reg_free_list;
  import rv32i_types::*;

  logic                clk = 1'b0;
  logic                rst;
  logic [SS-1:0]       alloc_req;
  logic                alloc_gnt;
  preg_idx_t           alloc_preg [SS];
  logic [SS-1:0]       commit_en;
  preg_idx_t           commit_old_preg [SS];
  logic                flush;
  logic [FL_IDX_W:0]   free_count;
  logic                err;

  int checks = 0;
  int errors = 0;

  phys_reg_free_list dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_req       (alloc_req),
    .alloc_gnt       (alloc_gnt),
    .alloc_preg      (alloc_preg),
    .commit_en       (commit_en),
    .commit_old_preg (commit_old_preg),
    .flush           (flush),
    .free_count      (free_count),
    .err             (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    alloc_req          = '0;
    commit_en          = '0;
    flush              = 1'b0;
    commit_old_preg[0] = '0;
    commit_old_preg[1] = '0;
  endtask

  // Advance one clock; inputs may be changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #3;
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL reset_free_count: got %0d expected 32", free_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL reset_gnt_noreq: got %b expected 1", alloc_gnt); end
    checks++; if (alloc_preg[0] !== 6'd32) begin errors++; $display("FAIL reset_head_entry: got %0d expected 32", alloc_preg[0]); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
  endtask

  task automatic test_dual_alloc();
    do_reset();
    alloc_req = 2'b11;
    #1;
    checks++; if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL dual_gnt: got %b expected 1", alloc_gnt); end
    checks++; if (alloc_preg[0] !== 6'd32 || alloc_preg[1] !== 6'd33) begin
      errors++; $display("FAIL dual_preg: got {%0d,%0d} expected {32,33}", alloc_preg[0], alloc_preg[1]); end
    tick();
    idle();
    #1;
    checks++; if (free_count !== 6'd30) begin errors++; $display("FAIL dual_free_count: got %0d expected 30", free_count); end
  endtask

  task automatic test_compaction();
    do_reset();
    alloc_req = 2'b10;
    #1;
    checks++; if (alloc_gnt !== 1'b1 || alloc_preg[1] !== 6'd32) begin
      errors++; $display("FAIL compact_way1: got gnt=%b preg=%0d expected gnt=1 preg=32", alloc_gnt, alloc_preg[1]); end
    tick();
    alloc_req = 2'b01;
    #1;
    checks++; if (alloc_preg[0] !== 6'd33 || free_count !== 6'd31) begin
      errors++; $display("FAIL compact_head_adv: got preg=%0d free=%0d expected preg=33 free=31", alloc_preg[0], free_count); end
    tick();
    idle();
  endtask

  task automatic test_empty();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_req = 2'b11;
      tick();
    end
    idle();
    #1;
    checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL empty_free_count: got %0d expected 0", free_count); end
    checks++; if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL empty_zero_req_gnt: got %b expected 1", alloc_gnt); end
    alloc_req          = 2'b01;
    commit_en          = 2'b01;
    commit_old_preg[0] = 6'd5;
    #1;
    checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL empty_deny: got %b expected 0", alloc_gnt); end
    tick();
    idle();
    alloc_req = 2'b01;
    #1;
    checks++; if (alloc_gnt !== 1'b1 || alloc_preg[0] !== 6'd5 || free_count !== 6'd1) begin
      errors++; $display("FAIL empty_refill: got gnt=%b preg=%0d free=%0d expected gnt=1 preg=5 free=1",
                         alloc_gnt, alloc_preg[0], free_count); end
    tick();
    idle();
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL empty_err: got %b expected 0", err); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_req = 2'b11;
    tick();
    tick();
    idle();
    commit_en          = 2'b01;
    commit_old_preg[0] = 6'd7;
    tick();
    idle();
    #1;
    checks++; if (free_count !== 6'd29) begin errors++; $display("FAIL flush_pre_count: got %0d expected 29", free_count); end
    flush     = 1'b1;
    alloc_req = 2'b01;
    #1;
    checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL flush_no_gnt: got %b expected 0", alloc_gnt); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL flush_free_count: got %0d expected 32", free_count); end
    checks++; if (alloc_gnt !== 1'b1 || alloc_preg[0] !== 6'd33) begin
      errors++; $display("FAIL flush_restart: got gnt=%b preg=%0d expected gnt=1 preg=33", alloc_gnt, alloc_preg[0]); end
    tick();
    idle();
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_err: got %b expected 0", err); end
  endtask

  task automatic test_wrap();
    preg_idx_t exp_q[$];
    preg_idx_t exp_preg;
    preg_idx_t pushed;
    do_reset();
    alloc_req = 2'b01;
    tick();
    idle();
    for (int k = 33; k < 64; k++) exp_q.push_back(preg_idx_t'(k));
    for (int k = 0; k < 70; k++) begin
      pushed             = preg_idx_t'(1 + (k % 31));
      alloc_req          = 2'b01;
      commit_en          = 2'b01;
      commit_old_preg[0] = pushed;
      #1;
      exp_preg = exp_q.pop_front();
      checks++; if (alloc_gnt !== 1'b1 || alloc_preg[0] !== exp_preg) begin
        errors++; $display("FAIL wrap_alloc[%0d]: got gnt=%b preg=%0d expected gnt=1 preg=%0d",
                           k, alloc_gnt, alloc_preg[0], exp_preg); end
      checks++; if (free_count !== 6'd31) begin
        errors++; $display("FAIL wrap_free_count[%0d]: got %0d expected 31", k, free_count); end
      exp_q.push_back(pushed);
      tick();
    end
    idle();
    #1;
    checks++; if (free_count !== 6'd31 || err !== 1'b0) begin
      errors++; $display("FAIL wrap_end: got free=%0d err=%b expected free=31 err=0", free_count, err); end
  endtask

  task automatic test_err_zero_preg();
    do_reset();
    alloc_req = 2'b01;
    tick();
    idle();
    commit_en          = 2'b01;
    commit_old_preg[0] = 6'd0;
    tick();
    idle();
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_zero_preg: got %b expected 1", err); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_err_async_reset();
    do_reset();
    commit_en          = 2'b01;
    commit_old_preg[0] = 6'd9;
    tick();
    idle();
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_overflow: got %b expected 1", err); end
    #2 rst = 1'b0;
    #1;
    checks++; if (err !== 1'b0 || free_count !== 6'd32) begin
      errors++; $display("FAIL async_reset: got err=%b free=%0d expected err=0 free=32", err, free_count); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    test_reset();
    test_dual_alloc();
    test_compaction();
    test_empty();
    test_flush();
    test_wrap();
    test_err_zero_preg();
    test_err_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
